ifetch_unit: RTL

Instruction-fetch stage sitting directly upstream of the register-file/decode stage. Holds the PC and requests words from instruction memory over a ready handshake. Presents a registered inst / pcOld / instValid triple to decode, and absorbs branch/jump redirects from execute with a one-cycle flush bubble.

---
 rtl/ifetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
// ifetch_unit: holds the PC, fetches over a ready handshake and presents a registered
// inst/pcOld/instValid triple to decode. Optional macro IFETCH_MISALIGN_TRAP_EN traps misaligned redirects.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] pcOld,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_old_q, pc_old_d;
    logic        inst_valid_q, inst_valid_d;
    logic        req;
    logic        accept;
    logic [31:0] target;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
    logic        target_misaligned;

    assign target            = redirectTarget;
    assign target_misaligned = |redirectTarget[1:0];
`else
    logic        target_lo_unused;

    assign target           = {redirectTarget[31:2], 2'b00};
    assign target_lo_unused = |redirectTarget[1:0];
`endif

    assign req    = (state_q == S_RUN) && (!inst_valid_q || !stall);
    assign accept = req && imemReady && !redirect;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        pc_old_d     = pc_old_q;
        inst_valid_d = inst_valid_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
`endif

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_FLUSH: state_d = S_RUN;
            default: state_d = state_q;
        endcase

        if (accept) begin
            inst_d       = imemData;
            pc_old_d     = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
        end else if (inst_valid_q && !stall) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
        end

        // Redirect overrides everything: squashes held inst even under stall, drops any response.
        if (redirect) begin
            pc_d         = target;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (target_misaligned) begin
                misalign_d = 1'b1;
                state_d    = S_TRAP;
            end else begin
                misalign_d = 1'b0;
                state_d    = S_FLUSH;
            end
`else
            state_d      = S_FLUSH;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            pc_old_q     <= 32'h0000_0000;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pc_old_q     <= pc_old_d;
            inst_valid_q <= inst_valid_d;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign imemReq   = req;
    assign imemAddr  = pc_q;
    assign instValid = inst_valid_q;
    assign inst      = inst_q;
    assign pcOld     = pc_old_q;

endmodule
`default_nettype wire
